// File: rtl/hazard_ctrl_if.sv
// hazard_ctrl_if
//   Bundle of decode-stage request signals and hazard-control responses that
//   pass between the decode stage and the hazard controller.
//
//   Decode -> controller:
//     id_valid   decode holds a real instruction
//     id_rs      source register 1, id_rs_en says it is read
//     id_rt      source register 2, id_rt_en says it is read
//     id_rd      destination register, id_wr says it is written
//     id_halt    instruction is HALT
//     br_flush   execute resolved a taken branch/jump this cycle
//   Controller -> pipeline:
//     stall      hold PC and IF/ID
//     bubble     force NOP control into ID/EX
//     flush      squash IF/ID contents
//     halted     pipe drained after HALT (sticky)
//     busy_mask  one-hot OR of registers with a valid in-flight write
//
//   master: the side that drives the decode requests (pipeline / testbench)
//   slave:  the hazard controller
interface hazard_ctrl_if;
  logic       id_valid;
  logic [2:0] id_rs;
  logic       id_rs_en;
  logic [2:0] id_rt;
  logic       id_rt_en;
  logic [2:0] id_rd;
  logic       id_wr;
  logic       id_halt;
  logic       br_flush;
  logic       stall;
  logic       bubble;
  logic       flush;
  logic       halted;
  logic [7:0] busy_mask;

  modport master (
    output id_valid, id_rs, id_rs_en, id_rt, id_rt_en, id_rd, id_wr,
           id_halt, br_flush,
    input  stall, bubble, flush, halted, busy_mask
  );

  modport slave (
    input  id_valid, id_rs, id_rs_en, id_rt, id_rt_en, id_rd, id_wr,
           id_halt, br_flush,
    output stall, bubble, flush, halted, busy_mask
  );
endinterface

// File: rtl/hazard_ctrl.sv
// hazard_ctrl
//   Pipeline hazard and sequencing controller for the five-stage core. Sits
//   beside decode and decides each cycle whether the decode instruction
//   issues, stalls or is squashed. Tracks in-flight register writes in a
//   shift-register scoreboard, raises a RAW stall against it, sequences
//   branch flushes from execute, and drains the pipe on HALT before raising
//   a sticky halted flag.
//
//   Parameters:
//     DEPTH      in-flight write stages tracked (ID/EX through WB)
//     BYPASS     1 = register file forwards the WB write, so the oldest
//                scoreboard entry is not a hazard
//     FLUSH_LEN  cycles flush stays asserted per taken branch/jump (1..7)
//
//   Ports:
//     clk   core clock
//     rst   synchronous, active-low reset
//     bus   hazard_ctrl_if.slave: decode requests in, stall/bubble/flush/
//           halted/busy_mask out
module hazard_ctrl #(
  parameter int DEPTH     = 3,
  parameter bit BYPASS    = 1'b1,
  parameter int FLUSH_LEN = 2
) (
  input logic          clk,
  input logic          rst,
  hazard_ctrl_if.slave bus
);

  // With write-back forwarding the oldest entry is already visible to the
  // register file read, so it is left out of the hazard compare.
  localparam int HAZ_N = BYPASS ? DEPTH - 1 : DEPTH;

  // The cycle br_flush is seen already counts as the first flush cycle, and
  // the FLUSH state's zero-count cycle is the last one, hence the -2.
  localparam logic [2:0] FLUSH_RELOAD = (FLUSH_LEN > 1) ? 3'(FLUSH_LEN - 2) : 3'd0;

  localparam logic [1:0] ST_RUN    = 2'd0;
  localparam logic [1:0] ST_FLUSH  = 2'd1;
  localparam logic [1:0] ST_DRAIN  = 2'd2;
  localparam logic [1:0] ST_HALTED = 2'd3;

  logic [1:0]       state_q, state_d;
  logic [2:0]       cnt_q, cnt_d;
  logic [DEPTH-1:0] sb_v_q, sb_v_d;
  logic [2:0]       sb_rd_q [DEPTH];
  logic [2:0]       sb_rd_d [DEPTH];

  logic       raw;
  logic       flush_w;
  logic       stall_w;
  logic       issue;
  logic       sb_empty;
  logic [7:0] busy_w;

  // RAW detect: decode reads a register that a not-yet-forwarded in-flight
  // instruction is going to write.
  always_comb begin
    raw = 1'b0;
    for (int k = 0; k < HAZ_N; k++) begin
      if (sb_v_q[k] &&
          ((bus.id_rs_en && (sb_rd_q[k] == bus.id_rs)) ||
           (bus.id_rt_en && (sb_rd_q[k] == bus.id_rt)))) begin
        raw = 1'b1;
      end
    end
    raw = raw & bus.id_valid;
  end

  assign sb_empty = ~|sb_v_q;
  assign flush_w  = bus.br_flush | (state_q == ST_FLUSH);

  // A taken branch outranks a RAW stall: the stalled instruction is on the
  // wrong path anyway. DRAIN and HALTED freeze the front end regardless.
  always_comb begin
    stall_w = 1'b0;
    case (state_q)
      ST_RUN:    stall_w = raw & ~flush_w;
      ST_FLUSH:  stall_w = 1'b0;
      ST_DRAIN:  stall_w = 1'b1;
      ST_HALTED: stall_w = 1'b1;
      default:   stall_w = 1'b0;
    endcase
  end

  assign issue = bus.id_valid & ~stall_w & ~flush_w & (state_q == ST_RUN);

  // Sequencing: flush window counting, HALT drain and the sticky halt.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    case (state_q)
      ST_RUN: begin
        if (bus.br_flush) begin
          if (FLUSH_LEN > 1) begin
            state_d = ST_FLUSH;
            cnt_d   = FLUSH_RELOAD;
          end
        end else if (issue && bus.id_halt) begin
          state_d = ST_DRAIN;
        end
      end
      ST_FLUSH: begin
        if (bus.br_flush) begin
          cnt_d = FLUSH_RELOAD;
        end else if (cnt_q == 3'd0) begin
          state_d = ST_RUN;
        end else begin
          cnt_d = cnt_q - 3'd1;
        end
      end
      ST_DRAIN: begin
        // A branch resolving behind the HALT means the HALT was wrong-path.
        if (bus.br_flush) begin
          if (FLUSH_LEN > 1) begin
            state_d = ST_FLUSH;
            cnt_d   = FLUSH_RELOAD;
          end else begin
            state_d = ST_RUN;
          end
        end else if (sb_empty) begin
          state_d = ST_HALTED;
        end
      end
      ST_HALTED: begin
        state_d = ST_HALTED;
      end
      default: begin
        state_d = ST_RUN;
        cnt_d   = 3'd0;
      end
    endcase
  end

  // Scoreboard advances one stage per cycle; only an issuing instruction
  // can enter, so stalled or squashed decode contents never appear here.
  always_comb begin
    sb_v_d     = '0;
    sb_v_d[0]  = issue & bus.id_wr;
    sb_rd_d[0] = issue ? bus.id_rd : 3'd0;
    for (int k = 1; k < DEPTH; k++) begin
      sb_v_d[k]  = sb_v_q[k-1];
      sb_rd_d[k] = sb_rd_q[k-1];
    end
  end

  // busy_mask covers every entry, including the bypassed one.
  always_comb begin
    busy_w = 8'h00;
    for (int k = 0; k < DEPTH; k++) begin
      if (sb_v_q[k]) begin
        busy_w[sb_rd_q[k]] = 1'b1;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      state_q <= ST_RUN;
      cnt_q   <= 3'd0;
      sb_v_q  <= '0;
      for (int k = 0; k < DEPTH; k++) begin
        sb_rd_q[k] <= 3'd0;
      end
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      sb_v_q  <= sb_v_d;
      for (int k = 0; k < DEPTH; k++) begin
        sb_rd_q[k] <= sb_rd_d[k];
      end
    end
  end

  assign bus.stall     = stall_w;
  assign bus.bubble    = stall_w | flush_w;
  assign bus.flush     = flush_w;
  assign bus.halted    = (state_q == ST_HALTED);
  assign bus.busy_mask = busy_w;

endmodule
